qdec: RTL



---
 rtl/qdec_pkg.sv | 38 +++
 rtl/qdec_sync_filter.sv | 39 +++
 rtl/qdec.sv | 111 +++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// Shared FSM states, Gray codes and the transition decoder for the quadrature decoder.
package qdec_pkg;

    localparam logic [0:0] StInit  = 1'b0;
    localparam logic [0:0] StTrack = 1'b1;

    // Forward (up) order: GrayS0 -> GrayS1 -> GrayS2 -> GrayS3 -> GrayS0, bits are {A, B}.
    localparam logic [1:0] GrayS0 = 2'b00;
    localparam logic [1:0] GrayS1 = 2'b10;
    localparam logic [1:0] GrayS2 = 2'b11;
    localparam logic [1:0] GrayS3 = 2'b01;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } trans_t;

    function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] cur);
        trans_t t;
        t = '0;
        if (prev != cur) begin
            if ((prev ^ cur) == 2'b11) begin
                t.illegal = 1'b1;
            end else begin
                t.valid = 1'b1;
                case (prev)
                    GrayS0:  t.up = (cur == GrayS1);
                    GrayS1:  t.up = (cur == GrayS2);
                    GrayS2:  t.up = (cur == GrayS3);
                    default: t.up = (cur == GrayS0);
                endcase
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Multi-flop synchroniser followed by a stability filter: the output only follows the
// synchronised input after it has differed for FILTER consecutive cycles.
module sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   q_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            q_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            if (sync_q[SYNC_STAGES-1] == q_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER - 1)) begin
                q_q   <= ~q_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign q = q_q;

endmodule

// File: rtl/qdec.sv
// Quadrature decoder: filtered A/B/index channels, Gray decode into step/dir strobes,
// index zero strobe and a sticky illegal-transition flag.
module qdec
    import qdec_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 4,
    parameter string       MODE        = "X4",
    parameter int unsigned INVERT_DIR  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic a,
    input  logic b,
    input  logic idx,
    input  logic err_clr,
    output logic step,
    output logic dir,
    output logic zero,
    output logic err
);

    localparam int unsigned InitCycles = SYNC_STAGES + FILTER + 1;
    localparam int unsigned IW         = $clog2(InitCycles);
    localparam logic        DirInv     = (INVERT_DIR != 0);
    localparam logic        ModeX2     = (MODE == "X2");
    localparam logic        ModeX1     = (MODE == "X1");

    logic a_f, b_f, idx_f;

    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_sync_a (
        .clk(clk), .rst_n(rst_n), .d(a), .q(a_f)
    );
    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_sync_b (
        .clk(clk), .rst_n(rst_n), .d(b), .q(b_f)
    );
    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_sync_idx (
        .clk(clk), .rst_n(rst_n), .d(idx), .q(idx_f)
    );

    logic [0:0]    state_q;
    logic [IW-1:0] init_cnt_q;
    logic [1:0]    prev_q;
    logic          idx_prev_q;
    logic          step_q, dir_q, zero_q, err_q;

    logic [1:0] cur;
    trans_t     tr;
    logic       counted;

    always_comb begin
        cur = {a_f, b_f};
        tr  = decode_trans(prev_q, cur);
        if (ModeX1) begin
            counted = tr.valid && (((prev_q == GrayS0) && (cur == GrayS1)) ||
                                   ((prev_q == GrayS1) && (cur == GrayS0)));
        end else if (ModeX2) begin
            counted = tr.valid && (prev_q[1] != cur[1]);
        end else begin
            counted = tr.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            prev_q     <= '0;
            idx_prev_q <= 1'b0;
            step_q     <= 1'b0;
            dir_q      <= ~DirInv;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            step_q     <= 1'b0;
            zero_q     <= 1'b0;
            idx_prev_q <= idx_f;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (state_q == StInit) begin
                // Wait until the synchronisers and filters have settled on the real levels.
                if (init_cnt_q == IW'(InitCycles - 1)) begin
                    state_q <= StTrack;
                    prev_q  <= cur;
                end else begin
                    init_cnt_q <= init_cnt_q + IW'(1);
                end
            end else begin
                prev_q <= cur;
                if (ena) begin
                    if (counted) begin
                        step_q <= 1'b1;
                        dir_q  <= tr.up ^ DirInv;
                    end
                    if (tr.illegal) begin
                        err_q <= 1'b1;
                    end
                    zero_q <= idx_f & ~idx_prev_q;
                end
            end
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign zero = zero_q;
    assign err  = err_q;

endmodule
